// File: rtl/dco_code_ctrl_if.sv
// Interface bundling the DCO code controller's control and status signals.
// Optional override ports exist only when DCO_CODE_FORCE_EN is defined.
interface dco_code_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             up;
    logic             dn;
    logic [WIDTH-1:0] code;
    logic             busy;
    logic             locked;
`ifdef DCO_CODE_FORCE_EN
    logic             force_en;
    logic [WIDTH-1:0] force_code;
`endif

    modport master (
        output start, up, dn,
`ifdef DCO_CODE_FORCE_EN
        output force_en, force_code,
`endif
        input  code, busy, locked
    );

    modport slave (
        input  start, up, dn,
`ifdef DCO_CODE_FORCE_EN
        input  force_en, force_code,
`endif
        output code, busy, locked
    );
endinterface

// File: rtl/dco_code_ctrl.sv
// DCO frequency acquisition and tracking controller.
// A binary search sets the coarse code, then a bang-bang integrator tracks it,
// and a lock flag rises after enough alternating tracking steps.
// Optional feature macro: DCO_CODE_FORCE_EN (adds a code override through the interface).
module dco_code_ctrl #(
    parameter int WIDTH      = 5,
    parameter int SETTLE_CYC = 16,
    parameter int TRACK_TH   = 4,
    parameter int LOCK_CNT   = 8
) (
    input  logic           clk,
    input  logic           rstb,
    dco_code_ctrl_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int AW = $clog2(TRACK_TH + 1) + 1;
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [WIDTH-1:0]     MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     MAXC     = {WIDTH{1'b1}};
    localparam logic [CW-1:0]        LAST_CYC = CW'(SETTLE_CYC - 1);
    localparam logic [BW-1:0]        TOP_BIT  = BW'(WIDTH - 1);
    localparam logic [LW-1:0]        LMAX     = LW'(LOCK_CNT);
    localparam logic signed [AW-1:0] ACC_ONE  = 1;
    localparam logic signed [AW-1:0] ACC_HI   = AW'(TRACK_TH);
    localparam logic signed [AW-1:0] ACC_LO   = -ACC_HI;

    typedef enum logic [1:0] {IDLE, SAR, TRACK} state_t;

    state_t                state, state_n;
    logic [WIDTH-1:0]      code, code_n;
    logic                  busy, busy_n;
    logic                  locked, locked_n;
    logic [BW-1:0]         bit_idx, bit_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic signed [AW-1:0]  acc, acc_n, acc_sum;
    logic [LW-1:0]         lcnt, lcnt_n;
    logic                  prev_up, prev_up_n;
    logic                  have_prev, have_prev_n;
    logic                  upd_up, upd_dn, rail;

    assign bus.code   = code;
    assign bus.busy   = busy;
    assign bus.locked = locked;

    // Register all controller state; every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            code      <= MID;
            busy      <= 1'b0;
            locked    <= 1'b0;
            bit_idx   <= TOP_BIT;
            cnt       <= '0;
            acc       <= '0;
            lcnt      <= '0;
            prev_up   <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            busy      <= busy_n;
            locked    <= locked_n;
            bit_idx   <= bit_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            lcnt      <= lcnt_n;
            prev_up   <= prev_up_n;
            have_prev <= have_prev_n;
        end
    end

    // Next-state logic: override, then restart, then the search or tracking step
    always_comb begin
        state_n     = state;
        code_n      = code;
        busy_n      = busy;
        locked_n    = locked;
        bit_n       = bit_idx;
        cnt_n       = cnt;
        acc_n       = acc;
        lcnt_n      = lcnt;
        prev_up_n   = prev_up;
        have_prev_n = have_prev;
        acc_sum     = acc;
        upd_up      = 1'b0;
        upd_dn      = 1'b0;
        rail        = 1'b0;

`ifdef DCO_CODE_FORCE_EN
        if (bus.force_en) begin
            state_n     = IDLE;
            code_n      = bus.force_code;
            busy_n      = 1'b0;
            locked_n    = 1'b0;
            acc_n       = '0;
            lcnt_n      = '0;
            have_prev_n = 1'b0;
        end else
`endif
        if (bus.start) begin
            state_n     = SAR;
            code_n      = MID;
            busy_n      = 1'b1;
            locked_n    = 1'b0;
            bit_n       = TOP_BIT;
            cnt_n       = '0;
            acc_n       = '0;
            lcnt_n      = '0;
            have_prev_n = 1'b0;
        end else begin
            case (state)
                SAR: begin
                    if (cnt == LAST_CYC) begin
                        cnt_n = '0;
                        if (!(bus.up && !bus.dn)) begin
                            code_n[bit_idx] = 1'b0;
                        end
                        if (bit_idx == '0) begin
                            state_n     = TRACK;
                            busy_n      = 1'b0;
                            acc_n       = '0;
                            lcnt_n      = '0;
                            locked_n    = 1'b0;
                            have_prev_n = 1'b0;
                        end else begin
                            code_n[bit_idx - BW'(1)] = 1'b1;
                            bit_n                    = bit_idx - BW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                TRACK: begin
                    if (bus.up && !bus.dn) begin
                        acc_sum = acc + ACC_ONE;
                    end else if (bus.dn && !bus.up) begin
                        acc_sum = acc - ACC_ONE;
                    end
                    acc_n  = acc_sum;
                    upd_up = (acc_sum == ACC_HI);
                    upd_dn = (acc_sum == ACC_LO);
                    if (upd_up || upd_dn) begin
                        acc_n = '0;
                        rail  = upd_up ? (code == MAXC) : (code == '0);
                        if (!rail) begin
                            code_n = upd_up ? code + WIDTH'(1) : code - WIDTH'(1);
                        end
                        if (rail || !have_prev) begin
                            lcnt_n = '0;
                        end else if (prev_up != upd_up) begin
                            lcnt_n = (lcnt == LMAX) ? lcnt : lcnt + LW'(1);
                        end else begin
                            lcnt_n = '0;
                        end
                        have_prev_n = 1'b1;
                        prev_up_n   = upd_up;
                        locked_n    = (lcnt_n == LMAX);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dco_code_ctrl.sv
// Self-checking bench for dco_code_ctrl with a rule-level reference model.
// Define DCO_CODE_FORCE_EN to also exercise the code override.
module tb_dco_code_ctrl;
    localparam int W       = 5;
    localparam int SC      = 16;
    localparam int TH      = 4;
    localparam int LC      = 8;
    localparam int MID     = 16;
    localparam int MAXC    = 31;
    localparam int SAR_CYC = W * SC;

    logic clk;
    logic rstb;
    int   checks;
    int   errors;

    int   m_code;
    int   m_acc;
    int   m_last;
    int   m_alt;
    bit   m_locked;

    dco_code_ctrl_if #(.WIDTH(W)) bus ();

    dco_code_ctrl #(
        .WIDTH(W), .SETTLE_CYC(SC), .TRACK_TH(TH), .LOCK_CNT(LC)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rule-level model of one tracking cycle: integer accumulator, code and alternation count
    task automatic model_track(input bit u, input bit d);
        int dir;
        dir = 0;
        if (u && !d) m_acc = m_acc + 1;
        else if (d && !u) m_acc = m_acc - 1;
        if (m_acc >= TH) dir = 1;
        else if (m_acc <= -TH) dir = -1;
        if (dir != 0) begin
            m_acc = 0;
            if (m_code + dir < 0 || m_code + dir > MAXC) begin
                m_alt = 0;
            end else begin
                m_code = m_code + dir;
                if (m_last == 0) m_alt = 0;
                else if (m_last != dir) m_alt = (m_alt + 1 > LC) ? LC : m_alt + 1;
                else m_alt = 0;
            end
            m_last   = dir;
            m_locked = (m_alt == LC);
        end
    endtask

    task automatic model_enter_track(input int target);
        m_code   = target;
        m_acc    = 0;
        m_last   = 0;
        m_alt    = 0;
        m_locked = 1'b0;
    endtask

    task automatic track_cycle(input bit u, input bit d);
        bus.up = u;
        bus.dn = d;
        tick();
        model_track(u, d);
    endtask

    // Closed-loop acquisition: the detector says "slow" while the code is at or below target
    task automatic acquire(input int target);
        bus.start = 1'b1;
        bus.up    = 1'b0;
        bus.dn    = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < SAR_CYC; i++) begin
            bus.up = (int'(bus.code) <= target);
            bus.dn = !bus.up;
            tick();
        end
        bus.up = 1'b0;
        bus.dn = 1'b0;
        model_enter_track(target);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.code !== 5'(MID) || bus.busy !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: code=%0d busy=%b locked=%b, expected code=%0d busy=0 locked=0",
                     bus.code, bus.busy, bus.locked, MID);
        end
        rstb = 1'b1;
    endtask

    task automatic test_sar();
        int targets[6];
        targets = '{21, 0, 31, 0, 0, 0};
        for (int k = 3; k < 6; k++) targets[k] = $urandom_range(0, MAXC);
        foreach (targets[k]) begin
            bus.start = 1'b1;
            bus.up    = 1'b0;
            bus.dn    = 1'b0;
            tick();
            bus.start = 1'b0;
            checks++;
            if (bus.code !== 5'(MID) || bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sar_enter: code=%0d busy=%b, expected code=%0d busy=1",
                         bus.code, bus.busy, MID);
            end
            for (int i = 1; i <= SAR_CYC; i++) begin
                bus.up = (int'(bus.code) <= targets[k]);
                bus.dn = !bus.up;
                tick();
                if (i == SAR_CYC - 1) begin
                    checks++;
                    if (bus.busy !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL sar_busy_early: busy=%b at cycle %0d, expected 1", bus.busy, i);
                    end
                end
            end
            checks++;
            if (bus.busy !== 1'b0 || int'(bus.code) != targets[k] || bus.locked !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sar_result: code=%0d busy=%b locked=%b, expected code=%0d busy=0 locked=0",
                         bus.code, bus.busy, bus.locked, targets[k]);
            end
            bus.up = 1'b0;
            bus.dn = 1'b0;
        end
    endtask

    task automatic test_saturation();
        acquire(MAXC);
        for (int i = 0; i < 8; i++) track_cycle(1'b1, 1'b0);
        checks++;
        if (int'(bus.code) != MAXC || bus.locked !== 1'b0 || int'(bus.code) != m_code) begin
            errors++;
            $display("[TB] FAIL sat_top: code=%0d locked=%b, expected code=31 locked=0", bus.code, bus.locked);
        end
        for (int i = 0; i < 4; i++) track_cycle(1'b0, 1'b1);
        checks++;
        if (int'(bus.code) != MAXC - 1 || int'(bus.code) != m_code) begin
            errors++;
            $display("[TB] FAIL sat_step_down: code=%0d, expected 30", bus.code);
        end
    endtask

    task automatic test_lock();
        acquire(21);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 4; i++) begin
                track_cycle(k % 2 == 0, k % 2 != 0);
                checks++;
                if (int'(bus.code) != m_code || bus.locked !== m_locked) begin
                    errors++;
                    $display("[TB] FAIL lock_seq: code=%0d locked=%b, expected code=%0d locked=%b",
                             bus.code, bus.locked, m_code, m_locked);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b1 || int'(bus.code) != 22) begin
            errors++;
            $display("[TB] FAIL lock_assert: locked=%b code=%0d, expected locked=1 code=22", bus.locked, bus.code);
        end
        for (int i = 0; i < 8; i++) track_cycle(1'b1, 1'b0);
        checks++;
        if (bus.locked !== 1'b0 || int'(bus.code) != 24) begin
            errors++;
            $display("[TB] FAIL lock_drop: locked=%b code=%0d, expected locked=0 code=24", bus.locked, bus.code);
        end
    endtask

    task automatic test_random_track();
        int  seg;
        bit  bias_up;
        bit  u;
        bit  d;
        acquire($urandom_range(4, 27));
        bias_up = 1'b1;
        for (int s = 0; s < 40; s++) begin
            seg = $urandom_range(3, 10);
            for (int i = 0; i < seg; i++) begin
                u = ($urandom_range(0, 3) != 0) ? bias_up : $urandom_range(0, 1);
                d = ($urandom_range(0, 3) != 0) ? !bias_up : $urandom_range(0, 1);
                track_cycle(u, d);
                checks++;
                if (int'(bus.code) != m_code || bus.locked !== m_locked || bus.busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL random_track: code=%0d locked=%b busy=%b, expected code=%0d locked=%b busy=0",
                             bus.code, bus.locked, bus.busy, m_code, m_locked);
                end
            end
            bias_up = !bias_up;
        end
    endtask

    task automatic test_reset_mid_track();
        acquire(5);
        for (int i = 0; i < 10; i++) track_cycle(1'b1, 1'b0);
        rstb = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
        checks++;
        if (bus.code !== 5'(MID) || bus.busy !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_track: code=%0d busy=%b locked=%b, expected code=16 busy=0 locked=0",
                     bus.code, bus.busy, bus.locked);
        end
        bus.up = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.up = 1'b0;
        checks++;
        if (bus.code !== 5'(MID)) begin
            errors++;
            $display("[TB] FAIL idle_hold: code=%0d, expected 16", bus.code);
        end
    endtask

    task automatic test_restart();
        int target;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            bus.up = 1'b1;
            bus.dn = 1'b0;
            tick();
        end
        checks++;
        if (int'(bus.code) != 28) begin
            errors++;
            $display("[TB] FAIL restart_mid: code=%0d, expected 28", bus.code);
        end
        target    = $urandom_range(0, MAXC);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.code !== 5'(MID) || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_enter: code=%0d busy=%b, expected code=16 busy=1", bus.code, bus.busy);
        end
        for (int i = 1; i <= SAR_CYC; i++) begin
            bus.up = (int'(bus.code) <= target);
            bus.dn = !bus.up;
            tick();
            if (i == SAR_CYC - 1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL restart_busy_early: busy=%b, expected 1", bus.busy);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || int'(bus.code) != target) begin
            errors++;
            $display("[TB] FAIL restart_done: code=%0d busy=%b, expected code=%0d busy=0", bus.code, bus.busy, target);
        end
        bus.up = 1'b0;
        bus.dn = 1'b0;
    endtask

    task automatic test_back_to_back();
        acquire(21);
        for (int i = 0; i < 3; i++) track_cycle(1'b1, 1'b0);
        bus.up    = 1'b1;
        bus.dn    = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.up    = 1'b0;
        checks++;
        if (bus.code !== 5'(MID) || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_priority: code=%0d busy=%b, expected code=16 busy=1", bus.code, bus.busy);
        end
        acquire(10);
        checks++;
        if (int'(bus.code) != 10 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back: code=%0d busy=%b, expected code=10 busy=0", bus.code, bus.busy);
        end
    endtask

`ifdef DCO_CODE_FORCE_EN
    task automatic test_force();
        acquire(25);
        bus.force_en   = 1'b1;
        bus.force_code = 5'd7;
        bus.start      = 1'b1;
        tick();
        checks++;
        if (bus.code !== 5'd7 || bus.locked !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL force_apply: code=%0d busy=%b locked=%b, expected code=7 busy=0 locked=0",
                     bus.code, bus.busy, bus.locked);
        end
        tick();
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.code !== 5'd7 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL force_start_ignored: code=%0d busy=%b, expected code=7 busy=0", bus.code, bus.busy);
        end
        bus.force_en   = 1'b0;
        bus.force_code = 5'd3;
        bus.up         = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.up = 1'b0;
        checks++;
        if (bus.code !== 5'd7 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL force_release: code=%0d busy=%b, expected code=7 busy=0", bus.code, bus.busy);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.code !== 5'(MID) || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL force_restart: code=%0d busy=%b, expected code=16 busy=1", bus.code, bus.busy);
        end
    endtask
`endif

    // Scenario sequence
    initial begin
        checks    = 0;
        errors    = 0;
        rstb      = 1'b0;
        bus.start = 1'b0;
        bus.up    = 1'b0;
        bus.dn    = 1'b0;
`ifdef DCO_CODE_FORCE_EN
        bus.force_en   = 1'b0;
        bus.force_code = '0;
`endif
        model_enter_track(MID);
        test_reset();
        test_sar();
        test_saturation();
        test_lock();
        test_random_track();
        test_reset_mid_track();
        test_restart();
        test_back_to_back();
`ifdef DCO_CODE_FORCE_EN
        test_force();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
